// File: rtl/id_issue_if.sv
// id_issue_if: groups the fetch handshake, the execute operand bundle and the
// writeback port of the decode/issue stage.
interface id_issue_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 4
);
    // fetch -> issue
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    // issue -> execute
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] value1;
    logic [DATA_W-1:0] value2;
    logic [DATA_W-1:0] immediate;
    logic [2:0]        alu_oc;
    logic              ir_op;
    logic [AW-1:0]     rd;
    // writeback -> register file
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;

    // The issue stage itself
    modport slave (
        input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, value1, value2, immediate, alu_oc, ir_op, rd
    );

    // Fetch/execute/writeback environment driving the stage
    modport master (
        output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, value1, value2, immediate, alu_oc, ir_op, rd
    );
endinterface

// File: rtl/id_issue.sv
// id_issue: decode/issue stage. Decodes fetched instructions, reads a 16x32
// register file with writeback write-through, tracks in-flight destinations in
// a pending scoreboard and presents a registered operand bundle to execute.
module id_issue #(
    parameter int NREGS  = 16,
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic       clk,
    input  logic       rst,
    id_issue_if.slave  bus
);

    // Sign-extend the instruction immediate to operand width
    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // Decoded instruction fields
    logic              w_ir_op;
    logic [2:0]        w_alu_oc;
    logic [AW-1:0]     w_rd;
    logic [AW-1:0]     w_rs1;
    logic [AW-1:0]     w_rs2;
    logic [IMM_W-1:0]  w_imm;

    assign w_ir_op  = bus.instr[31];
    assign w_alu_oc = bus.instr[30:28];
    assign w_rd     = bus.instr[27:24];
    assign w_rs1    = bus.instr[23:20];
    assign w_rs2    = bus.instr[19:16];
    assign w_imm    = bus.instr[15:0];

    // Architectural state
    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_pend;

    // Output bundle (one register stage after capture)
    logic                     r_vld_p1;
    logic [DATA_W-1:0]        r_value1_p1;
    logic [DATA_W-1:0]        r_value2_p1;
    logic signed [DATA_W-1:0] r_imm_p1;
    logic [2:0]               r_alu_oc_p1;
    logic                     r_ir_op_p1;
    logic [AW-1:0]            r_rd_p1;

    // Control wires
    logic [NREGS-1:0]  w_wb_clr;
    logic [NREGS-1:0]  w_cap_set;
    logic [NREGS-1:0]  w_eff_pend;
    logic              w_hazard;
    logic              w_in_ready;
    logic              w_capture;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    // A writeback landing this cycle already resolves its pending bit, so the
    // hazard check looks at the scoreboard with that bit removed.
    assign w_wb_clr   = bus.wb_en ? (NREGS'(1) << bus.wb_addr) : '0;
    assign w_eff_pend = r_pend & ~w_wb_clr;
    assign w_hazard   = bus.in_valid &&
                        (w_eff_pend[w_rs1] ||
                         (w_ir_op && w_eff_pend[w_rs2]) ||
                         w_eff_pend[w_rd]);
    assign w_in_ready = (!r_vld_p1 || bus.out_ready) && !w_hazard;
    assign w_capture  = bus.in_valid && w_in_ready;
    assign w_cap_set  = (w_capture && (w_rd != '0)) ? (NREGS'(1) << w_rd) : '0;

    // Operand read: R0 is hard zero, a same-cycle writeback is forwarded
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != '0) begin
            if (bus.wb_en && (bus.wb_addr == w_rs1)) w_rs1_val = bus.wb_data;
            else                                      w_rs1_val = r_regs[w_rs1];
        end
        if (w_rs2 != '0) begin
            if (bus.wb_en && (bus.wb_addr == w_rs2)) w_rs2_val = bus.wb_data;
            else                                      w_rs2_val = r_regs[w_rs2];
        end
    end

    // Register file write from writeback; R0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (bus.wb_en && (bus.wb_addr != '0)) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Scoreboard: writeback clears, capture sets (set wins), bit 0 stays clear
    always_ff @(posedge clk) begin
        if (rst) r_pend <= '0;
        else     r_pend <= ((r_pend & ~w_wb_clr) | w_cap_set) & ~NREGS'(1);
    end

    // ---- stage p0 (decode/read) -> p1 (operand bundle to execute) ----
    // Output register: load on capture, drop valid when consumed, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_value1_p1 <= '0;
            r_value2_p1 <= '0;
            r_imm_p1    <= '0;
            r_alu_oc_p1 <= '0;
            r_ir_op_p1  <= 1'b0;
            r_rd_p1     <= '0;
        end else if (w_capture) begin
            r_vld_p1    <= 1'b1;
            r_value1_p1 <= w_rs1_val;
            r_value2_p1 <= w_rs2_val;
            r_imm_p1    <= sext_imm(w_imm);
            r_alu_oc_p1 <= w_alu_oc;
            r_ir_op_p1  <= w_ir_op;
            r_rd_p1     <= w_rd;
        end else if (bus.out_ready) begin
            r_vld_p1    <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vld_p1;
    assign bus.value1    = r_value1_p1;
    assign bus.value2    = r_value2_p1;
    assign bus.immediate = r_imm_p1;
    assign bus.alu_oc    = r_alu_oc_p1;
    assign bus.ir_op     = r_ir_op_p1;
    assign bus.rd        = r_rd_p1;

endmodule
